// File: rtl/dmem_pkg.sv
// Shared types and widths for the data memory responder and its storage array.
package dmem_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int BE_W   = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: byte-enable write or registered full-word read when en is high.
module dmem_array
    import dmem_pkg::*;
#(
    parameter  int DEPTH_WORDS = 256,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Contents are deliberately not reset; rdata only changes on a read access.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// Single-outstanding valid/ready word memory responder with a fixed response latency.
// Define DMEM_ERR_RESP_EN to flag misaligned or out-of-range accesses instead of wrapping.
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int                DEPTH_WORDS = 256,
    parameter int                LATENCY     = 2,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [BE_W-1:0]   req_be_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DATA_W-1:0] resp_rdata_o,
    output logic              resp_err_o
);

    localparam int               IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    dmem_req_t         req_in, req_q, acc;
    logic [ADDR_W-1:0] off;
    logic              accept, enter_resp, acc_err;
    logic              err_q, rd_ok_q;
    logic [DATA_W-1:0] arr_rdata;

    assign req_in      = '{we: req_we_i, addr: req_addr_i, wdata: req_wdata_i, be: req_be_i};
    assign req_ready_o = rst_i && (state_q == IDLE);
    assign accept      = req_valid_i && req_ready_o;

    // With LATENCY = 0 the array is accessed on the accept edge, so use the live request.
    assign acc        = (state_q == IDLE) ? req_in : req_q;
    assign off        = acc.addr - BASE_ADDR;
    assign enter_resp = (state_d == RESP) && (state_q != RESP);

`ifdef DMEM_ERR_RESP_EN
    localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(DEPTH_WORDS) << 2;
    // Below-base addresses wrap to a huge offset and fail the span check too.
    assign acc_err = (off[1:0] != 2'b00) || ({1'b0, off} >= SPAN);
`else
    logic unused_off_bits;
    assign acc_err         = 1'b0;
    assign unused_off_bits = ^{off[1:0], off[ADDR_W-1:IDX_W+2]};
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = (LATENCY == 0) ? RESP : WAIT;
            WAIT:    if (cnt_q == CNT_W'(1)) state_d = RESP;
            RESP:    if (resp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        resp_valid_o = (state_q == RESP);
        resp_err_o   = err_q;
        resp_rdata_o = rd_ok_q ? arr_rdata : '0;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            req_q <= '0;
            cnt_q <= '0;
        end else if (state_q == IDLE && accept) begin
            req_q <= req_in;
            cnt_q <= LAT_C;
        end else if (state_q == WAIT) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Response qualifiers are latched with the array access and held through RESP.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_q   <= 1'b0;
            rd_ok_q <= 1'b0;
        end else if (enter_resp) begin
            err_q   <= acc_err;
            rd_ok_q <= !acc.we && !acc_err;
        end else if (state_q == RESP && resp_ready_i) begin
            err_q   <= 1'b0;
            rd_ok_q <= 1'b0;
        end
    end

    dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk   (clk_i),
        .en    (enter_resp && !acc_err),
        .we    (acc.we),
        .idx   (off[IDX_W+1:2]),
        .wdata (acc.wdata),
        .be    (acc.be),
        .rdata (arr_rdata)
    );

endmodule
